// File: rtl/prng_lfsr_stream_pkg.sv
// Shared types and constants for the LFSR word generator.
// Holds the controller state encoding and default feedback masks per LFSR width.
package prng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } prng_state_e;

  localparam logic [8:0]  TAPS_W9  = 9'h108;
  localparam logic [15:0] TAPS_W16 = 16'hD008;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;
  localparam logic [63:0] TAPS_W64 = 64'hD800_0000_0000_0000;

  // Unlisted widths fall back to a two-tap mask that is not guaranteed maximal.
  function automatic logic [63:0] default_taps(input int w);
    logic [63:0] t;
    t = (64'd1 << (w - 1)) | 64'd1;
    case (w)
      9:       t = 64'(TAPS_W9);
      16:      t = 64'(TAPS_W16);
      32:      t = 64'(TAPS_W32);
      64:      t = TAPS_W64;
      default: ;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/prng_lfsr_stream_if.sv
// Control and output-stream bundle between the generator and its neighbours.
// master = generator side, slave = seed/control source plus word consumer.
interface prng_lfsr_stream_if #(
  parameter int LFSR_W = 9,
  parameter int OUT_W  = 512,
  parameter int CNT_W  = 16
);
  logic [LFSR_W-1:0] seed;
  logic              seed_valid;
  logic              start;
  logic [CNT_W-1:0]  num_words;
  logic              busy;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              done;

  modport master (
    input  seed, seed_valid, start, num_words, out_ready,
    output busy, out_data, out_valid, out_last, done
  );

  modport slave (
    output seed, seed_valid, start, num_words, out_ready,
    input  busy, out_data, out_valid, out_last, done
  );
endinterface

// File: rtl/prng_lfsr_stream_step.sv
// Combinational unroll of STEP Fibonacci LFSR steps.
// o_bits is MSB-first: the earliest emitted bit lands at o_bits[STEP-1].
module lfsr_step_unroll #(
  parameter int                LFSR_W = 9,
  parameter logic [LFSR_W-1:0] TAPS   = 9'h108,
  parameter int                STEP   = 1
) (
  input  logic [LFSR_W-1:0] i_lfsr,
  output logic [LFSR_W-1:0] o_lfsr_next,
  output logic [STEP-1:0]   o_bits
);

  always_comb begin
    logic [LFSR_W-1:0] v;
    v      = i_lfsr;
    o_bits = '0;
    for (int s = 0; s < STEP; s++) begin
      o_bits[STEP-1-s] = v[0];
      v = {v[LFSR_W-2:0], ^(v & TAPS)};
    end
    o_lfsr_next = v;
  end

endmodule

// File: rtl/prng_lfsr_stream.sv
// LFSR pseudo-random word generator: a start/done job emits num_words OUT_W-bit words
// over a valid/ready stream, advancing STEP LFSR steps per FILL cycle.
module prng_lfsr_stream
  import prng_pkg::*;
#(
  parameter int                LFSR_W = 9,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(default_taps(LFSR_W)),
  parameter int                OUT_W  = 512,
  parameter int                STEP   = 1,
  parameter int                CNT_W  = 16
) (
  input logic                clk,
  input logic                rst,
  prng_lfsr_stream_if.master bus
);

  localparam int K    = OUT_W / STEP;
  localparam int SC_W = (K > 1) ? $clog2(K) : 1;

  prng_state_e       r_state;
  prng_state_e       w_state_next;
  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_lfsr_next;
  logic [LFSR_W-1:0] w_seed_fix;
  logic [STEP-1:0]   w_bits;
  logic [OUT_W-1:0]  r_acc;
  logic [OUT_W-1:0]  w_acc_next;
  logic [OUT_W-1:0]  r_out_data;
  logic [CNT_W-1:0]  r_words_left;
  logic [SC_W-1:0]   r_step_cnt;
  logic              r_done;
  logic              w_fill_last;
  logic              w_job_load;
  logic              w_job_empty;
  logic              w_hs;
  logic              w_job_end;

  lfsr_step_unroll #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .STEP   (STEP)
  ) u_step (
    .i_lfsr      (r_lfsr),
    .o_lfsr_next (w_lfsr_next),
    .o_bits      (w_bits)
  );

  assign w_acc_next  = (r_acc << STEP) | OUT_W'(w_bits);
  assign w_fill_last = (r_step_cnt == SC_W'(K - 1));
  // An all-zero state would lock the LFSR, so a zero seed is promoted to 1.
  assign w_seed_fix  = (bus.seed == '0) ? LFSR_W'(1) : bus.seed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_job_load   = 1'b0;
    w_job_empty  = 1'b0;
    w_hs         = 1'b0;
    w_job_end    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.num_words != '0) begin
            w_job_load   = 1'b1;
            w_state_next = ST_FILL;
          end else begin
            w_job_empty = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (w_fill_last) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          w_hs = 1'b1;
          if (r_words_left == CNT_W'(1)) begin
            w_job_end    = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_FILL;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // LFSR only moves in FILL, so it is frozen in HOLD and persists across jobs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr       <= LFSR_W'(1);
      r_words_left <= '0;
      r_step_cnt   <= '0;
      r_out_data   <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_job_empty | w_job_end;
      case (r_state)
        ST_IDLE: begin
          if (bus.seed_valid) r_lfsr <= w_seed_fix;
          if (w_job_load) begin
            r_words_left <= bus.num_words;
            r_step_cnt   <= '0;
          end
        end
        ST_FILL: begin
          r_lfsr     <= w_lfsr_next;
          r_step_cnt <= w_fill_last ? '0 : r_step_cnt + SC_W'(1);
          if (w_fill_last) r_out_data <= w_acc_next;
        end
        ST_HOLD: begin
          if (w_hs) r_words_left <= r_words_left - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Every accumulator bit is rewritten within one FILL pass, so it needs no reset.
  always_ff @(posedge clk) begin
    if (r_state == ST_FILL) r_acc <= w_acc_next;
  end

  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.out_valid = (r_state == ST_HOLD);
  assign bus.out_last  = (r_state == ST_HOLD) && (r_words_left == CNT_W'(1));
  assign bus.out_data  = r_out_data;
  assign bus.done      = r_done;

endmodule
